// File: rtl/bfg_mux_test_sequencer.sv
// rtl/bfg_mux_test_sequencer.sv - sweeps all 64 mux vectors and scores both macro implementations
module bfg_mux_test_sequencer #(
    parameter int SETTLE_W = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle,
    output logic [3:0]          mux_i,
    output logic [1:0]          mux_s,
    input  logic                bfg_out_i,
    input  logic                gf_out_i,
    output logic [5:0]          vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [6:0]          bfg_err_cnt,
    output logic [6:0]          gf_err_cnt,
    output logic [5:0]          first_fail_vec,
    output logic                first_fail_valid
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [SETTLE_W-1:0] ONE = SETTLE_W'(1);

    state_t              state_q, state_d;
    logic [5:0]          vec_q, vec_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [SETTLE_W-1:0] n_q, n_d;
    logic [6:0]          bfg_err_q, bfg_err_d;
    logic [6:0]          gf_err_q, gf_err_d;
    logic [5:0]          ff_vec_q, ff_vec_d;
    logic                ff_valid_q, ff_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic [SETTLE_W-1:0] n_eff;
    logic [3:0]          data_bits;
    logic                exp_val;
    logic                bfg_bad;
    logic                gf_bad;

    // Drives come straight off the vec register so the macro sees them one edge earlier.
    assign mux_i     = vec_q[3:0];
    assign mux_s     = vec_q[5:4];
    assign data_bits = vec_q[3:0];
    assign exp_val   = data_bits[vec_q[5:4]];
    assign bfg_bad   = (bfg_out_i != exp_val);
    assign gf_bad    = (gf_out_i != exp_val);
    assign n_eff     = (settle == '0) ? ONE : settle;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        bfg_err_d  = bfg_err_q;
        gf_err_d   = gf_err_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;

        if (abort) begin
            state_d = S_IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (cnt_q == ONE) begin
                        if (bfg_bad) bfg_err_d = bfg_err_q + 7'd1;
                        if (gf_bad)  gf_err_d  = gf_err_q + 7'd1;
                        if ((bfg_bad || gf_bad) && !ff_valid_q) begin
                            ff_vec_d   = vec_q;
                            ff_valid_d = 1'b1;
                        end
                        if (vec_q == 6'd63) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (bfg_err_d == 7'd0) && (gf_err_d == 7'd0);
                        end else begin
                            vec_d = vec_q + 6'd1;
                            cnt_d = n_q;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    if (start) begin
                        state_d    = S_RUN;
                        vec_d      = '0;
                        n_d        = n_eff;
                        cnt_d      = n_eff;
                        bfg_err_d  = '0;
                        gf_err_d   = '0;
                        ff_vec_d   = '0;
                        ff_valid_d = 1'b0;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        pass_d     = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            bfg_err_q  <= '0;
            gf_err_q   <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            bfg_err_q  <= bfg_err_d;
            gf_err_q   <= gf_err_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign bfg_err_cnt      = bfg_err_q;
    assign gf_err_cnt       = gf_err_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: doc/bfg_mux_test_sequencer.md
# bfg_mux_test_sequencer

Self-checking stimulus controller for the 4:1 mux test macro (`bfg_mux_test_small`), which has inputs i0..i3 and s0/s1 and two implementations whose outputs are bfg_out and gf_out. On `start`, the block sweeps all 64 select/data combinations and holds each one for a programmable settle time. At the end of each hold it compares both mux outputs against the golden mux function and accumulates per-implementation error counts plus the first failing vector. It sits in the user project wrapper between the Wishbone/LA control plane and the mux macro.

## Interface
Parameters:
- `SETTLE_W`, default 8: width of the settle-count input and the internal settle counter.

Ports:
- `wb_clk_i`  in  1  block clock.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request, sampled each rising edge.
- `abort`  in  1  terminate sweep, sampled each rising edge.
- `settle`  in  SETTLE_W  cycles each vector is held; latched on accepted start; 0 is treated as 1.
- `mux_i`  out  4  data drive to the macro; bit n drives i_n.
- `mux_s`  out  2  select drive to the macro; bit 0 drives s0, bit 1 drives s1.
- `bfg_out_i`  in  1  bfg_out return from the macro.
- `gf_out_i`  in  1  gf_out return from the macro.
- `vec`  out  6  current vector index.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep completed; held until the next start or abort.
- `pass`  out  1  equals done AND both error counts are zero.
- `bfg_err_cnt`  out  7  bfg_out mismatch count, range 0..64.
- `gf_err_cnt`  out  7  gf_out mismatch count, range 0..64.
- `first_fail_vec`  out  6  lowest vector index at which either output mismatched.
- `first_fail_valid`  out  1  first_fail_vec holds a valid index.

## Operation
- Vector encoding: `mux_s = vec[5:4]`, `mux_i = vec[3:0]`. Golden value is `exp = mux_i[mux_s]`.
- All outputs are registered. mux_i and mux_s follow vec combinationally from the vec register, with no extra stage.
- States:
  - IDLE: busy=0, done=0, mux drives 0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, mux drives hold the last vector (63).
- IDLE or DONE, start=1, abort=0 → RUN. On this transition the block:
  - sets vec to 0,
  - loads the settle counter with N = max(settle,1),
  - clears both error counts, first_fail_vec and first_fail_valid.
- RUN: the settle counter decrements every cycle. When it reaches its last cycle (count==1), that edge is the compare edge:
  - If bfg_out_i != exp, bfg_err_cnt increments.
  - If gf_out_i != exp, gf_err_cnt increments.
  - If either output mismatched and first_fail_valid=0, first_fail_vec is set to vec and first_fail_valid is set to 1.
  - If vec==63, go to DONE. Otherwise increment vec and reload the counter with N.
- The latched N is fixed for the whole sweep; changes on `settle` during RUN are ignored.
- start during RUN is ignored.
- abort=1 in any state → IDLE on the next edge:
  - vec and mux drives go to 0,
  - done and pass go to 0,
  - error counts and first-fail fields retain their values.
- start and abort asserted in the same cycle: abort wins.
- The returns are combinational functions of the registered drives. No synchronizer is used; N is chosen to cover the macro plus pad delay.

## Timing
- Reset values (asserted asynchronously, released synchronously to the clock):
  - state=IDLE,
  - vec, mux_i, mux_s = 0,
  - busy, done, pass = 0,
  - both error counts = 0,
  - first_fail_vec = 0, first_fail_valid = 0.
- Sweep timeline, with start accepted at edge k:
  - busy=1 and vector 0 is driven from edge k.
  - Vector v is driven from edge k+v·N.
  - Vector v is compared at edge k+(v+1)·N.
- The final compare is at edge k+64·N. At that edge busy=0 and done=1, and pass becomes valid in the same cycle.
- Total busy time is exactly 64·N cycles.
- Error counts become visible one cycle after their compare edge.
- Reset asserted mid-sweep: all outputs return to their reset values immediately. No sweep resumes after reset release.

## Test plan
- **Ideal model, settle=1.** Both returns equal the golden mux. Start → busy for exactly 64 cycles, then done=1, pass=1, both counts 0, first_fail_valid=0.
- **gf_out stuck-at-0, settle=2.** Start → busy for 128 cycles, gf_err_cnt=32, bfg_err_cnt=0, first_fail_vec=1, first_fail_valid=1, pass=0.
- **bfg_out inverted, settle=3.** Start → bfg_err_cnt=64, gf_err_cnt=0, first_fail_vec=0. Also check the drive sequence: mux_s/mux_i step through vec 0..63 in order, changing exactly every 3 cycles.
- **Abort, then restart.** Abort while vec=10 → next cycle IDLE, busy=0, mux drives 0, done=0. A following start → fresh sweep with counts cleared.
- **Edge cases.**
  - settle=0 → behaves as N=1 (64-cycle sweep).
  - start pulsed mid-sweep → no effect.
  - start and abort in the same cycle from DONE → IDLE.
  - start from DONE → done drops on the next edge.
- **Reset during sweep.** wb_rst_ni pulled low at vec=40 → all outputs reach reset values immediately. After release, state stays IDLE until start.
